rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Arbitrates one shared single-port memory between instruction fetch (IF) and load/store (DM) in the RV32I core.
- Allows one outstanding transaction at a time.
- DM has priority by default. An aging counter guarantees IF forward progress.
- Sits between the core's fetch/LSU stages and the unified memory model.

Parameters:
- BW_ADDR, 32, address width.
- BW_DATA, 32, data width (multiple of 8).
- STARVE_MAX, 4, number of consecutive lost arbitrations after which IF is forced to win (1..15).

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  synchronous active-low reset
- i_if_req  input  1  IF read request; held until o_if_gnt
- i_if_addr  input  BW_ADDR  IF read address
- o_if_gnt  output  1  IF request accepted by memory
- o_if_rvalid  output  1  IF read data valid
- o_if_rdata  output  BW_DATA  IF read data
- i_dm_req  input  1  DM request; held until o_dm_gnt
- i_dm_we  input  1  DM write enable
- i_dm_addr  input  BW_ADDR  DM address
- i_dm_wdata  input  BW_DATA  DM write data
- i_dm_wstrb  input  BW_DATA/8  DM byte strobes
- o_dm_gnt  output  1  DM request accepted
- o_dm_rvalid  output  1  DM read data / write ack valid
- o_dm_rdata  output  BW_DATA  DM read data
- o_mem_req  output  1  memory request
- o_mem_we  output  1  memory write enable
- o_mem_addr  output  BW_ADDR  memory address
- o_mem_wdata  output  BW_DATA  memory write data
- o_mem_wstrb  output  BW_DATA/8  memory byte strobes
- i_mem_gnt  input  1  memory accepts request this cycle
- i_mem_rvalid  input  1  memory response (read data or write ack)
- i_mem_rdata  input  BW_DATA  memory read data
- o_busy  output  1  high whenever state != IDLE

Behaviour:
- One clock (i_clk); reset is synchronous, active-low (i_rstn), sampled on posedge i_clk.
- State machine: IDLE, REQ, RSP. An owner register (IF/DM) records the current transaction.
- Reset values: state=IDLE; owner=IF; starve_cnt=0; o_mem_req, o_mem_we=0; o_mem_addr, o_mem_wdata, o_mem_wstrb=0. All gnt/rvalid outputs are 0; o_busy=0.
- IDLE, neither request: stay.
- IDLE, arbitration when any request is present:
  - IF wins if only i_if_req is set, or if both are set and starve_cnt==STARVE_MAX.
  - Otherwise DM wins.
  - Winner's command is registered onto o_mem_*; o_mem_req=1 next cycle; owner is latched; go to REQ.
  - IF reads drive o_mem_we=0 and o_mem_wstrb=0; o_mem_wdata is don't-care (0).
- starve_cnt, updated only on IDLE arbitration:
  - Both requesting and DM wins: increment, saturating at STARVE_MAX.
  - IF wins: clear to 0.
  - Otherwise: hold.
- REQ: o_mem_* are held stable.
  - On i_mem_gnt: owner's gnt = 1 for that cycle, combinationally (i_mem_gnt & o_mem_req & owner match). o_mem_req falls next cycle; go to RSP.
  - i_mem_gnt in the same cycle o_mem_req rises is legal.
- RSP: o_mem_req=0.
  - On i_mem_rvalid: owner's rvalid = 1 that cycle; owner's rdata = i_mem_rdata (combinational); go to IDLE.
  - Writes also complete on i_mem_rvalid (ack). rdata is don't-care for writes.
- Non-owner rdata outputs are driven 0. Any i_mem_rvalid outside RSP is ignored.
- The request signals of a requester are not sampled outside IDLE. A request that drops before its gnt is protocol violation and need not be handled.
- Throughput: minimum 3 cycles per transaction (IDLE→REQ→RSP→IDLE) with immediate gnt/rvalid. Arbitration for the next request happens in the IDLE cycle after rvalid.
- Reset mid-operation (any state): return to IDLE with all reset values. The outstanding response is dropped, and a later stray i_mem_rvalid is ignored.

Test Plan:
- Reset: hold i_rstn=0 two cycles with i_dm_req=1 → o_mem_req=0, o_busy=0, no gnt. Release → o_mem_req=1 one cycle later with DM address.
- Single IF read: i_if_addr=0x100, mem gnt immediate, rvalid 2 cycles later with rdata=0xDEADBEEF → o_if_gnt one pulse; o_if_rvalid one pulse with 0xDEADBEEF; o_dm_* stay 0.
- DM write: addr=0x2004, wdata=0x12345678, wstrb=4'b0011 → o_mem_we=1 with those exact values held through a 3-cycle gnt stall. o_dm_rvalid pulses on ack.
- Contention/aging, STARVE_MAX=4: both request continuously → DM wins 4 arbitrations, IF wins the 5th, then the pattern repeats.
- Stray response: i_mem_rvalid=1 while IDLE and while in REQ → no rvalid output, state unchanged.
- Reset during RSP: assert i_rstn=0 for one cycle, then i_mem_rvalid arrives → no rvalid to either requester; next IF request arbitrates normally with starve_cnt=0.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM).
// At most one transaction is outstanding. DM wins by default, and an aging counter lets IF through.
module rv32i_mem_arbiter #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_if_req,
  input  logic [BW_ADDR-1:0]   i_if_addr,
  output logic                 o_if_gnt,
  output logic                 o_if_rvalid,
  output logic [BW_DATA-1:0]   o_if_rdata,
  input  logic                 i_dm_req,
  input  logic                 i_dm_we,
  input  logic [BW_ADDR-1:0]   i_dm_addr,
  input  logic [BW_DATA-1:0]   i_dm_wdata,
  input  logic [BW_DATA/8-1:0] i_dm_wstrb,
  output logic                 o_dm_gnt,
  output logic                 o_dm_rvalid,
  output logic [BW_DATA-1:0]   o_dm_rdata,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [BW_ADDR-1:0]   o_mem_addr,
  output logic [BW_DATA-1:0]   o_mem_wdata,
  output logic [BW_DATA/8-1:0] o_mem_wstrb,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [BW_DATA-1:0]   i_mem_rdata,
  output logic                 o_busy,
  output logic [1:0]           o_dbg_state
);

  localparam int BW_STRB = BW_DATA / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Handshake: a requester raises req with its command stable and holds it until the
  // cycle its gnt is high; the memory accepts when i_mem_gnt meets o_mem_req, and the
  // single response (read data or write ack) is the one i_mem_rvalid seen in RSP.

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic [3:0]         starve_q, starve_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [BW_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [BW_DATA-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW_STRB-1:0] mem_wstrb_q, mem_wstrb_d;

  logic if_wins;
  logic mem_accept;
  logic rsp_done;

  // IF only overrides a competing DM request once it has lost STARVE_MAX times in a row.
  assign if_wins = i_if_req & (~i_dm_req | (starve_q == STARVE_LIM));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (i_if_req || i_dm_req) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
          if (if_wins) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_DM;
            mem_we_d    = i_dm_we;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
            mem_wstrb_d = i_dm_wstrb;
            if (i_if_req && (starve_q < STARVE_LIM)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end

      ST_REQ: begin
        if (i_mem_gnt) begin
          state_d   = ST_RSP;
          mem_req_d = 1'b0;
        end
      end

      ST_RSP: begin
        if (i_mem_rvalid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Grants and responses are combinational so the requester sees them in the same cycle.
  assign mem_accept = i_mem_gnt & mem_req_q;
  assign rsp_done   = (state_q == ST_RSP) & i_mem_rvalid;

  assign o_if_gnt    = mem_accept & (owner_q == OWN_IF);
  assign o_dm_gnt    = mem_accept & (owner_q == OWN_DM);
  assign o_if_rvalid = rsp_done & (owner_q == OWN_IF);
  assign o_dm_rvalid = rsp_done & (owner_q == OWN_DM);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;

  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed and randomized checks of rv32i_mem_arbiter against a transaction-level model
// with a bench-side memory and an expected-read-data queue.
module tb_rv32i_mem_arbiter;

  localparam int SM = 4;

  logic        clk;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  rv32i_mem_arbiter #(.BW_ADDR(32), .BW_DATA(32), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_wstrb(dm_wstrb),
    .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        win_log[$];
  logic [31:0] mem_m [logic [31:0]];

  // Transaction-level model: phase 0 free, 1 command offered, 2 awaiting response.
  int          m_ph;
  logic        m_own;
  int          m_lose;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic [31:0] rd_val;
  logic        drop_if, drop_dm;
  int unsigned p_if, p_dm, p_gnt, p_rv, p_stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
    m_ph = 0; m_own = 0; m_lose = 0;
    drop_if = 0; drop_dm = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = v;
  endfunction

  // One cycle of requesters + memory + model. Entered 1 time unit after a rising edge.
  task automatic engine_cycle();
    logic e_if_g, e_dm_g, e_if_rv, e_dm_rv, iw;
    logic [31:0] ev;

    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("dbg_state_nonidle", 32'(dbg_state != 2'd0), 32'(m_ph != 0));
    chk("mem_req", 32'(mem_req), 32'(m_ph == 1));
    if (m_ph == 1) begin
      chk("mem_addr", mem_addr, c_addr);
      chk("mem_we", 32'(mem_we), 32'(c_we));
      chk("mem_wdata", mem_wdata, c_wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(c_wstrb));
    end

    if (drop_if) begin if_req = 0; drop_if = 0; end
    if (drop_dm) begin dm_req = 0; drop_dm = 0; end
    if (!if_req && $urandom_range(0, 99) < p_if) begin
      if_req  = 1;
      if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    end
    if (!dm_req && $urandom_range(0, 99) < p_dm) begin
      dm_req   = 1;
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      dm_wdata = $urandom;
      dm_wstrb = 4'($urandom_range(0, 15));
    end
    mem_gnt = (m_ph == 1) ? ($urandom_range(0, 99) < p_gnt) : ($urandom_range(0, 99) < p_stray);
    if (m_ph == 2) begin
      mem_rvalid = ($urandom_range(0, 99) < p_rv);
      mem_rdata  = (m_own && c_we) ? $urandom : rd_val;
    end else begin
      mem_rvalid = ($urandom_range(0, 99) < p_stray);
      mem_rdata  = $urandom;
    end
    settle();

    e_if_g  = (m_ph == 1) && mem_gnt && !m_own;
    e_dm_g  = (m_ph == 1) && mem_gnt && m_own;
    e_if_rv = (m_ph == 2) && mem_rvalid && !m_own;
    e_dm_rv = (m_ph == 2) && mem_rvalid && m_own;
    chk("if_gnt", 32'(if_gnt), 32'(e_if_g));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dm_g));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
    if (e_if_rv) begin
      ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("if_rdata", if_rdata, ev);
      chk("dm_rdata_idle", dm_rdata, 32'h0);
    end
    if (e_dm_rv) begin
      if (!c_we) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("dm_rdata", dm_rdata, ev);
      end
      chk("if_rdata_idle", if_rdata, 32'h0);
    end
    if (if_gnt) win_log.push_back(1'b0);
    if (dm_gnt) win_log.push_back(1'b1);

    case (m_ph)
      0: if (if_req || dm_req) begin
        iw = if_req && (!dm_req || m_lose == SM);
        if (iw) m_lose = 0;
        else if (if_req && m_lose < SM) m_lose++;
        m_own = !iw;
        if (iw) begin
          c_we = 0; c_addr = if_addr; c_wdata = 0; c_wstrb = 0;
        end else begin
          c_we = dm_we; c_addr = dm_addr; c_wdata = dm_wdata; c_wstrb = dm_wstrb;
        end
        m_ph = 1;
      end
      1: if (mem_gnt) begin
        if (m_own) drop_dm = 1; else drop_if = 1;
        if (m_own && c_we) mem_wr(c_addr, c_wdata, c_wstrb);
        else begin
          rd_val = mem_rd(c_addr);
          exp_q.push_back(rd_val);
        end
        m_ph = 2;
      end
      default: if (mem_rvalid) m_ph = 0;
    endcase
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      engine_cycle();
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 0;
    clear_inputs();

    // Reset holds everything idle even with a DM request pending.
    dm_req = 1; dm_addr = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
    end
    rstn = 1;
    tick();
    chk("rel_mem_req", 32'(mem_req), 32'h1);
    chk("rel_mem_addr", mem_addr, 32'h40);
    chk("rel_busy", 32'(busy), 32'h1);
    mem_gnt = 1;
    settle();
    chk("rel_dm_gnt", 32'(dm_gnt), 32'h1);
    chk("rel_if_gnt", 32'(if_gnt), 32'h0);
    tick();
    dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    settle();
    chk("rel_rsp_mem_req", 32'(mem_req), 32'h0);
    chk("rel_dm_rvalid", 32'(dm_rvalid), 32'h1);
    chk("rel_dm_rdata", dm_rdata, 32'h55);
    tick();
    mem_rvalid = 0;
    chk("rel_done_busy", 32'(busy), 32'h0);

    // Single IF read with response two cycles after grant.
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("ifr_mem_addr", mem_addr, 32'h100);
    chk("ifr_mem_we", 32'(mem_we), 32'h0);
    chk("ifr_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("ifr_mem_wdata", mem_wdata, 32'h0);
    mem_gnt = 1;
    settle();
    chk("ifr_if_gnt", 32'(if_gnt), 32'h1);
    chk("ifr_dm_gnt", 32'(dm_gnt), 32'h0);
    tick();
    if_req = 0; mem_gnt = 0;
    settle();
    chk("ifr_gnt_pulse", 32'(if_gnt), 32'h0);
    chk("ifr_early_rvalid", 32'(if_rvalid), 32'h0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("ifr_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("ifr_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("ifr_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("ifr_dm_rdata", dm_rdata, 32'h0);
    tick();
    mem_rvalid = 0;
    settle();
    chk("ifr_rvalid_pulse", 32'(if_rvalid), 32'h0);
    chk("ifr_busy", 32'(busy), 32'h0);

    // DM write held stable through a three-cycle grant stall.
    dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("dmw_mem_req", 32'(mem_req), 32'h1);
      chk("dmw_mem_we", 32'(mem_we), 32'h1);
      chk("dmw_mem_addr", mem_addr, 32'h2004);
      chk("dmw_mem_wdata", mem_wdata, 32'h12345678);
      chk("dmw_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk("dmw_no_gnt", 32'(dm_gnt), 32'h0);
      tick();
    end
    mem_gnt = 1;
    settle();
    chk("dmw_dm_gnt", 32'(dm_gnt), 32'h1);
    tick();
    dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    settle();
    chk("dmw_dm_rvalid", 32'(dm_rvalid), 32'h1);
    chk("dmw_if_rvalid", 32'(if_rvalid), 32'h0);
    tick();
    mem_rvalid = 0;

    // Stray responses in IDLE and REQ are ignored.
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    settle();
    chk("stray_idle_if_rv", 32'(if_rvalid), 32'h0);
    chk("stray_idle_dm_rv", 32'(dm_rvalid), 32'h0);
    tick();
    chk("stray_idle_busy", 32'(busy), 32'h0);
    mem_rvalid = 0; if_req = 1; if_addr = 32'h300;
    tick();
    mem_rvalid = 1;
    settle();
    chk("stray_req_if_rv", 32'(if_rvalid), 32'h0);
    tick();
    chk("stray_req_mem_req", 32'(mem_req), 32'h1);
    chk("stray_req_busy", 32'(busy), 32'h1);
    mem_rvalid = 0; mem_gnt = 1;
    settle();
    chk("stray_req_if_gnt", 32'(if_gnt), 32'h1);
    tick();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    settle();
    chk("stray_rsp_if_rv", 32'(if_rvalid), 32'h1);
    chk("stray_rsp_if_rdata", if_rdata, 32'h77);
    tick();
    mem_rvalid = 0;

    // Build up IF starvation, then reset during the response of the fourth DM win.
    for (int i = 0; i < 4; i++) begin
      if_req = 1; if_addr = 32'h600;
      dm_req = 1; dm_we = 0; dm_addr = 32'h500 + 32'(i * 4);
      tick();
      chk("starve_dm_wins", mem_addr, 32'h500 + 32'(i * 4));
      mem_gnt = 1;
      tick();
      mem_gnt = 0;
      if (i < 3) begin
        mem_rvalid = 1; mem_rdata = 32'h1;
        tick();
        mem_rvalid = 0;
      end
    end
    rstn = 0; if_req = 0; dm_req = 0;
    tick();
    chk("rsp_rst_busy", 32'(busy), 32'h0);
    chk("rsp_rst_mem_req", 32'(mem_req), 32'h0);
    chk("rsp_rst_mem_addr", mem_addr, 32'h0);
    rstn = 1; mem_rvalid = 1; mem_rdata = 32'hAA;
    settle();
    chk("rsp_rst_if_rv", 32'(if_rvalid), 32'h0);
    chk("rsp_rst_dm_rv", 32'(dm_rvalid), 32'h0);
    tick();
    mem_rvalid = 0;
    chk("rsp_rst_idle", 32'(busy), 32'h0);
    if_req = 1; if_addr = 32'h600; dm_req = 1; dm_addr = 32'h700;
    tick();
    chk("post_rst_arb_addr", mem_addr, 32'h700);
    mem_gnt = 1;
    tick();
    mem_gnt = 0; if_req = 0; dm_req = 0; mem_rvalid = 1;
    settle();
    chk("post_rst_dm_rv", 32'(dm_rvalid), 32'h1);
    tick();
    mem_rvalid = 0;

    // Continuous contention with an ideal memory: DM x4, then IF, repeating.
    do_reset();
    win_log.delete();
    p_if = 100; p_dm = 100; p_gnt = 100; p_rv = 100; p_stray = 0;
    for (int i = 0; i < 200 && win_log.size() < 10; i++) begin
      engine_cycle();
      tick();
    end
    chk("contention_count", 32'(win_log.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < win_log.size()) chk("contention_winner", 32'(win_log[k]), 32'((k % 5) != 4));
    end

    // Randomized traffic: moderate load with strays, then heavy load on a slow memory.
    p_if = 40; p_dm = 40; p_gnt = 50; p_rv = 50; p_stray = 10;
    run_random(3000);
    p_if = 90; p_dm = 90; p_gnt = 30; p_rv = 30; p_stray = 15;
    run_random(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
